// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver.
package serial_frame_pkg;

  // Frame sequencer states, binary encoded.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Serial line levels.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic C,
  input  logic R,
  input  logic clear,
  output logic tick
);

  // A one-clock bit period still needs a 1-bit counter.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_next;

  assign tick = !clear && (count_reg == LAST);

  // Next count: hold at zero while cleared, wrap on the tick.
  always_comb begin
    count_next = count_reg + TW'(1);
    if (clear || tick) begin
      count_next = '0;
    end
  end

  // Count register.
  always_ff @(posedge C) begin
    if (R) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start, LSB-first data, optional even
// parity, stop. All outputs are registered and move together with the state.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              C,
  input  logic              R,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state_reg,  state_next;
  logic [DATA_W-1:0] shift_reg,  shift_next;
  logic [IW-1:0]     idx_reg,    idx_next;
  logic              parity_reg, parity_next;
  logic              tx_reg,     tx_next;
  logic              ready_reg,  ready_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;

  logic              accept;
  logic              tick;
  logic              timer_clear;
  logic [DATA_W-1:0] shift_dn;

  assign accept      = valid_i && ready_reg;
  assign timer_clear = accept || (state_reg == ST_IDLE);
  assign shift_dn    = shift_reg >> 1;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .C    (C),
    .R    (R),
    .clear(timer_clear),
    .tick (tick)
  );

  // Next-state and registered-output logic; every state but IDLE advances on the tick.
  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    idx_next    = idx_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    ready_next  = ready_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        tx_next    = LINE_IDLE;
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (accept) begin
          shift_next  = data_i;
          parity_next = ^data_i;
          idx_next    = '0;
          state_next  = ST_START;
          tx_next     = LINE_START;
          ready_next  = 1'b0;
          busy_next   = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_next = ST_DATA;
          tx_next    = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = shift_dn;
          idx_next   = idx_reg + IW'(1);
          if (idx_reg == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_next = ST_PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = LINE_IDLE;
            end
          end else begin
            tx_next = shift_dn[0];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
          tx_next    = LINE_IDLE;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_next = ST_IDLE;
          tx_next    = LINE_IDLE;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = LINE_IDLE;
        ready_next = 1'b1;
        busy_next  = 1'b0;
        idx_next   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge C) begin
    if (R) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      idx_reg    <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= LINE_IDLE;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      idx_reg    <= idx_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign tx_o    = tx_reg;
  assign ready_o = ready_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (4/2/parity and 4/1/no parity)
// compared every cycle against a frame-list model, plus literal frame checks.
module tb_serial_frame_tx;

  logic C = 1'b0;
  always #5 C = ~C;

  logic [1:0]      rst;
  logic [1:0]      valid;
  logic [1:0][3:0] data;
  logic [1:0]      rdy, tx, busy, done;

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(2), .PARITY_EN(1)) dut_a (
    .C(C), .R(rst[0]), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .C(C), .R(rst[1]), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of line levels, one per clock; the model replays it.
  bit [1:0] m_tx, m_rdy, m_busy, m_done;
  int       m_len [2];
  int       m_pos [2];
  bit       fb [2][64];

  function automatic int cpb_of(input int id);
    return (id == 0) ? 2 : 1;
  endfunction

  function automatic bit pe_of(input int id);
    return (id == 0);
  endfunction

  task automatic build_frame(input int id, input logic [3:0] d);
    bit bits [8];
    int nb;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 4; i++) bits[nb++] = d[i];
    if (pe_of(id)) bits[nb++] = ^d;
    bits[nb++] = 1'b1;
    m_len[id] = 0;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < cpb_of(id); r++)
        fb[id][m_len[id]++] = bits[b];
  endtask

  task automatic model_step(input int id);
    if (rst[id]) begin
      m_tx[id] = 1; m_rdy[id] = 1; m_busy[id] = 0; m_done[id] = 0;
      m_len[id] = 0; m_pos[id] = 0;
    end else if (m_rdy[id] && valid[id]) begin
      build_frame(id, data[id]);
      m_tx[id] = fb[id][0]; m_pos[id] = 1;
      m_rdy[id] = 0; m_busy[id] = 1; m_done[id] = 0;
    end else if (m_busy[id]) begin
      if (m_pos[id] < m_len[id]) begin
        m_tx[id] = fb[id][m_pos[id]];
        m_pos[id]++;
      end else begin
        m_tx[id] = 1; m_rdy[id] = 1; m_busy[id] = 0; m_done[id] = 1;
      end
    end else begin
      m_done[id] = 0;
    end
  endtask

  always @(posedge C) begin
    for (int id = 0; id < 2; id++) model_step(id);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge C) begin
    if (chk_en) begin
      for (int id = 0; id < 2; id++) begin
        chk($sformatf("model tx dut%0d", id),    32'(tx[id]),   32'(m_tx[id]));
        chk($sformatf("model ready dut%0d", id), 32'(rdy[id]),  32'(m_rdy[id]));
        chk($sformatf("model busy dut%0d", id),  32'(busy[id]), 32'(m_busy[id]));
        chk($sformatf("model done dut%0d", id),  32'(done[id]), 32'(m_done[id]));
      end
    end
  end

  // ---------------- directed tasks ----------------
  task automatic send_cap(input int id, input logic [3:0] d, input int n,
                          input logic [31:0] exp, input bit poke, input string nm);
    logic [31:0] cap;
    cap = '0;
    @(negedge C);
    chk({nm, " ready before accept"}, 32'(rdy[id]), 32'd1);
    valid[id] = 1'b1;
    data[id]  = d;
    @(negedge C);
    valid[id] = 1'b0;
    for (int k = 0; k < n; k++) begin
      cap[n-1-k] = tx[id];
      if (poke && k == 4) begin valid[id] = 1'b1; data[id] = ~d; end
      if (poke && k == 5) valid[id] = 1'b0;
      @(negedge C);
    end
    chk({nm, " frame"}, cap, exp);
    chk({nm, " done pulse"}, 32'(done[id]), 32'd1);
    chk({nm, " ready at done"}, 32'(rdy[id]), 32'd1);
    @(negedge C);
    chk({nm, " done one cycle"}, 32'(done[id]), 32'd0);
    $display("frame %s dut%0d data=%h tx=%h", nm, id, d, cap);
  endtask

  task automatic back_to_back();
    logic [31:0] cap;
    cap = '0;
    @(negedge C);
    valid[0] = 1'b1;
    data[0]  = 4'h3;
    @(negedge C);
    data[0] = 4'hC;
    for (int k = 0; k < 29; k++) begin
      cap[28-k] = tx[0];
      if (k == 14) begin
        chk("b2b done on gap", 32'(done[0]), 32'd1);
      end
      if (k == 15) valid[0] = 1'b0;
      @(negedge C);
    end
    chk("b2b frames", cap, {3'b0, 14'b00111100000011, 1'b1, 14'b00000011110011});
    chk("b2b second done", 32'(done[0]), 32'd1);
    $display("frame b2b dut0 data=3,C tx=%h", cap);
  endtask

  task automatic reset_mid_frame();
    @(negedge C);
    valid[0] = 1'b1;
    data[0]  = 4'b1010;
    @(negedge C);
    valid[0] = 1'b0;
    repeat (4) @(negedge C);
    rst[0] = 1'b1;
    @(negedge C);
    rst[0] = 1'b0;
    chk("reset mid tx",    32'(tx[0]),   32'd1);
    chk("reset mid ready", 32'(rdy[0]),  32'd1);
    chk("reset mid busy",  32'(busy[0]), 32'd0);
    for (int k = 0; k < 20; k++) begin
      chk("reset mid no done", 32'(done[0]), 32'd0);
      @(negedge C);
    end
    $display("reset mid-frame dut0 checked");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst   = 2'b11;
    valid = 2'b00;
    data  = '0;
    repeat (3) @(posedge C);
    @(negedge C);
    rst    = 2'b00;
    chk_en = 1'b1;
    for (int id = 0; id < 2; id++) begin
      chk("reset tx",    32'(tx[id]),   32'd1);
      chk("reset ready", 32'(rdy[id]),  32'd1);
      chk("reset busy",  32'(busy[id]), 32'd0);
      chk("reset done",  32'(done[id]), 32'd0);
    end

    send_cap(0, 4'b1010, 14, 32'(14'b00001100110011), 1'b0, "a_1010");
    send_cap(0, 4'b0111, 14, 32'(14'b00111111001111), 1'b0, "a_0111");
    back_to_back();
    repeat (3) @(negedge C);
    send_cap(0, 4'b1010, 14, 32'(14'b00001100110011), 1'b1, "a_busy_poke");
    repeat (5) @(negedge C);
    chk("no extra frame", 32'(busy[0]), 32'd0);
    reset_mid_frame();
    send_cap(0, 4'b0111, 14, 32'(14'b00111111001111), 1'b0, "a_after_reset");
    send_cap(1, 4'hF, 6, 32'(6'b011111), 1'b0, "b_F");

    // Randomized traffic with occasional resets on both instances.
    for (int c = 0; c < 1500; c++) begin
      @(negedge C);
      for (int id = 0; id < 2; id++) begin
        valid[id] = ($urandom_range(0, 3) != 0);
        data[id]  = 4'($urandom);
        rst[id]   = ($urandom_range(0, 119) == 0);
      end
    end
    @(negedge C);
    valid = 2'b00;
    rst   = 2'b00;
    repeat (40) @(negedge C);
    $display("random phase dut0/dut1 complete");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial framed transmitter for the testarch feature tests.
- It is the transmit end of the registered input-capture path: it accepts DATA_W-bit words over a valid/ready handshake and drives them out on one pad as a start/data/parity/stop frame.
- It is instantiated behind an OB and paired with a capture design on the receive side.
- Flip-flops are plain DFFs; next-state and muxing logic map to LUTs.

Parameters:
- DATA_W, 4, payload bits per frame; legal range 1..16.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range 1..255.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous active-high reset.
- data_i  input  DATA_W  word to send; sampled only on the accept edge.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (R high at a rising edge of C), registered values after that edge:
  - state=IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0, bit timer=0, bit index=0.
  - R has priority over every other event.
- Accept: valid_i && ready_o at a rising edge.
  - data_i is loaded into the shift register.
  - Parity = XOR of data_i is latched.
  - Next state is START; ready_o=0 and busy_o=1 take effect from the same edge.
  - data_i and valid_i are ignored while ready_o=0. No error is flagged and nothing is queued.
- States and tx_o values:
  - IDLE: tx_o=1.
  - START: tx_o=0.
  - DATA: tx_o=shift-register LSB; bits go out LSB first.
  - PARITY: tx_o=latched parity. Skipped when PARITY_EN=0.
  - STOP: tx_o=1.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and issues a tick on the last count.
  - Each state other than IDLE lasts exactly CLKS_PER_BIT cycles.
  - In DATA, the shift register shifts right and the bit index increments on each tick.
  - DATA exits after DATA_W ticks.
- tx_o is registered and changes on the same edge as the state.
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, counted from the cycle after accept.
- Frame completion, on the STOP tick:
  - Next state is IDLE; ready_o=1, busy_o=0, done_o=1 for exactly one cycle.
  - done_o cannot re-pulse without a new frame.
- Back-to-back frames:
  - A word presented while done_o=1 (ready_o=1) is accepted on that edge, and its start bit begins the following cycle.
  - tx_o is therefore high for exactly one cycle between frames.
- CLKS_PER_BIT=1: the tick fires every cycle, so there is one cycle per bit and no special-casing.
- Reset mid-frame:
  - The frame is abandoned; tx_o=1 from the next edge.
  - No done_o pulse; the shifted word is lost.
- Width rules:
  - Bit timer width = clog2(CLKS_PER_BIT), minimum 1.
  - Bit index width = clog2(DATA_W+1).
  - No wrap beyond the terminal count is reachable.

Decomposition:
- Shared package serial_frame_pkg:
  - State encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit, binary).
  - Line level constants LINE_IDLE=1, LINE_START=0.
  - The same package is used by the matching receiver test.
- One sub-module, serial_bit_timer:
  - Parameter CLKS_PER_BIT; inputs C, R, clear; output tick.
  - clear is asserted on accept and in IDLE.
- The FSM, shift register and parity live in serial_frame_tx.

Test Plan:
- DATA_W=4, CLKS_PER_BIT=2, PARITY_EN=1, send 4'b1010:
  - tx_o = 0,0 | 0,0,1,1,0,0,1,1 | 0,0 | 1,1, which is 14 cycles.
  - done_o is high for 1 cycle after the last stop cycle; ready_o returns to 1 on that cycle.
- Same configuration, send 4'b0111:
  - Parity bit is 1 (cycles 11-12).
  - Data bits are 1,1,1,0 LSB first.
- Back-to-back: hold valid_i=1 with 4'h3 then 4'hC:
  - The second word is accepted on the done_o cycle.
  - Exactly one idle-high cycle separates the frames.
  - The second frame is bit-exact.
- Word presented while busy:
  - Toggle data_i and pulse valid_i mid-frame.
  - The frame is unchanged, no extra frame follows, and ready_o stays 0 until done_o.
- Reset mid-frame: assert R during DATA (cycle 5).
  - Next edge: tx_o=1, ready_o=1, busy_o=0.
  - No done_o pulse; the next accepted word produces a clean frame.
- DATA_W=4, CLKS_PER_BIT=1, PARITY_EN=0, send 4'hF:
  - tx_o = 0,1,1,1,1,1 over 6 cycles, then done_o.
  - No parity state is visited.
